// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with start-bit-aligned baud counter and mid-bit sampling.
// Define UART_RX_PARITY_EN for an 8E1 frame with an even-parity check.
module uart_rx_byte #(
    parameter int unsigned BAUD_DIV  = 10416,
    parameter int unsigned BAUD_HALF = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [13:0] HALF_LAST = 14'(BAUD_HALF - 1);
    localparam logic [13:0] DIV_LAST  = 14'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        line;
    logic        fall;
    logic [13:0] baud_cnt;
    logic [13:0] baud_nxt;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_nxt;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        ferr_nxt;
    logic        par_err;
    logic        par_nxt;

    // sync2 is the conditioned line; sync3 only exists for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign line = sync2;
    assign fall = sync3 & ~sync2;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
            par_err   <= par_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = (state == S_IDLE) ? 14'd0 : baud_cnt + 14'd1;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        par_nxt   = par_err;

        unique case (state)
            S_IDLE: begin
                if (fall) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_nxt = '0;
                    bit_nxt  = '0;
                    par_nxt  = 1'b0;
                    // a line back high at mid-start is a glitch, not a frame
                    state_nxt = line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_cnt == DIV_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = {line, shift_reg[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_cnt == DIV_LAST) begin
                    baud_nxt  = '0;
                    par_nxt   = line ^ (^shift_reg);
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_cnt == DIV_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                    if (line && !par_err) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: frame-level model with event queue.
// Works in both the 8N1 build and the UART_RX_PARITY_EN build.
module tb_uart_rx_byte;

    localparam int D = 16;
    localparam int H = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 3 + H + 9 * D + PB * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(.BAUD_DIV(D), .BAUD_HALF(H)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_i(rx_i),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t        q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_data = 8'h00;
    int         nvalid = 0;
    int         nferr = 0;
    int         last_v_cyc = 0;
    logic [7:0] last_v_data = 8'h00;
    logic       last_v_busy = 1'b1;
    int         t0 = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  dlt;
        if (rst_n) begin
            if (rx_valid || frame_err) begin
                chk("exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
                if (rx_valid) begin
                    nvalid++;
                    last_v_cyc  = cyc;
                    last_v_data = rx_data;
                    last_v_busy = busy;
                end
                if (frame_err) nferr++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: valid=%0d ferr=%0d want none (cycle %0d)",
                             rx_valid, frame_err, cyc);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    dlt = cyc - e.at;
                    total++;
                    if (dlt < -1 || dlt > 1) begin
                        bad++;
                        $display("FAIL event_time: got cycle %0d want %0d +-1", cyc, e.at);
                    end
                    if (!e.is_err) exp_data = e.data;
                    chk("busy_at_end", {31'd0, busy}, 32'd0);
                end
            end else if (q.size() > 0 && cyc > q[0].at + 1) begin
                total++;
                bad++;
                $display("FAIL missed_event: got none want data %0h by cycle %0d",
                         q[0].data, q[0].at + 1);
                void'(q.pop_front());
            end
            chk("rx_data", {24'd0, rx_data}, {24'd0, exp_data});
        end
    end

    task automatic drive(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_len,
                              input logic stop_v, input logic par_v);
        ev_t e;
        t0 = cyc;
        e.at = cyc + LAT;
        e.data = b;
        e.is_err = !stop_v || (PB == 1 && par_v != ^b);
        q.push_back(e);
        drive(1'b0, D);
        for (int i = 0; i < 8; i++) drive(b[i], D);
        if (PB == 1) drive(par_v, D);
        drive(stop_v, stop_len);
    endtask

    task automatic good_frame(input logic [7:0] b, input int stop_len);
        send_frame(b, stop_len, 1'b1, ^b);
    endtask

    initial begin
        int n0;
        int f0;
        int bcnt;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 20);

        // single frame 0xA5
        n0 = nvalid;
        f0 = nferr;
        good_frame(8'hA5, D);
        drive(1'b1, D);
        chk("a5_count", nvalid - n0, 32'd1);
        chk("a5_ferr", nferr - f0, 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("a5_latency", last_v_cyc - t0, 32'd171);
`else
        chk("a5_latency", last_v_cyc - t0, 32'd155);
`endif
        chk("a5_data", {24'd0, last_v_data}, 32'h000000A5);
        chk("a5_busy_fall", {31'd0, last_v_busy}, 32'd0);

        // back-to-back, second stop bit cut short to 9 cycles
        n0 = nvalid;
        good_frame(8'h00, D);
        good_frame(8'hFF, 9);
        good_frame(8'h55, D);
        drive(1'b1, 2 * D);
        chk("b2b_count", nvalid - n0, 32'd3);
        chk("b2b_last", {24'd0, last_v_data}, 32'h00000055);

        // 4-cycle glitch
        n0 = nvalid;
        f0 = nferr;
        bcnt = 0;
        rx_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            if (busy) bcnt++;
        end
        rx_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (busy) bcnt++;
        end
        total++;
        if (bcnt < 7 || bcnt > 9) begin
            bad++;
            $display("FAIL glitch_busy: got %0d cycles want 8 +-1", bcnt);
        end
        chk("glitch_valid", nvalid - n0, 32'd0);
        chk("glitch_ferr", nferr - f0, 32'd0);

        // stop bit low, then break
        f0 = nferr;
        n0 = nvalid;
        send_frame(8'h3C, D, 1'b0, ^8'h3C);
        chk("ferr_count", nferr - f0, 32'd1);
        chk("ferr_hold", {24'd0, rx_data}, 32'h00000055);
        bcnt = 0;
        for (int i = 0; i < 10 * D; i++) begin
            @(posedge clk);
            #2;
            if (busy) bcnt++;
        end
        chk("break_busy", bcnt, 32'd0);
        chk("break_ferr", nferr - f0, 32'd1);
        chk("break_valid", nvalid - n0, 32'd0);
        drive(1'b1, 2 * D);
        good_frame(8'h3C, D);
        drive(1'b1, D);
        chk("after_break", {24'd0, last_v_data}, 32'h0000003C);

        // reset during data bit 4 of 0x81
        n0 = nvalid;
        f0 = nferr;
        b = 8'h81;
        drive(1'b0, D);
        for (int i = 0; i < 4; i++) drive(b[i], D);
        drive(b[4], 6);
        rst_n = 1'b0;
        exp_data = 8'h00;
        #1;
        chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
        chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 2 * D);
        chk("rst_no_pulse", (nvalid - n0) + (nferr - f0), 32'd0);
        good_frame(8'h81, D);
        drive(1'b1, D);
        chk("after_rst", {24'd0, last_v_data}, 32'h00000081);

`ifdef UART_RX_PARITY_EN
        n0 = nvalid;
        f0 = nferr;
        send_frame(8'h07, D, 1'b1, 1'b1);
        drive(1'b1, D);
        chk("par_ok_valid", nvalid - n0, 32'd1);
        chk("par_ok_data", {24'd0, last_v_data}, 32'h00000007);
        send_frame(8'h07, D, 1'b1, 1'b0);
        drive(1'b1, D);
        chk("par_bad_ferr", nferr - f0, 32'd1);
        chk("par_bad_valid", nvalid - n0, 32'd1);
`endif

        for (int i = 0; i < 4 * D && q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
